// File: rtl/la_ulpi_regctl.sv
// ULPI link-side register access controller: single PHY register writes/reads
// with nxt/dir flow control, abort retry, timeout and RX CMD capture.
//
// state  | meaning
// IDLE   | no transaction; bus released to 0x00, requests accepted
// TXCMD  | driving register TX CMD, waiting for nxt
// WDATA  | driving write data, waiting for nxt
// WSTP   | stop cycle closing a register write
// RTURN  | read: waiting for PHY to take the bus (turnaround)
// RDATA  | read: sampling register data from PHY
// RWAIT  | read: waiting for PHY to release the bus
// ABWAIT | PHY grabbed the bus before accepting TX CMD; retry once dir drops
module la_ulpi_regctl #(
  parameter string TARGET = "DEFAULT",
  parameter int    TOW    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       req_ready,
  output logic       done_valid,
  output logic       done_err,
  output logic [7:0] done_rdata,
  output logic       busy,
  output logic       rxcmd_valid,
  output logic [7:0] rxcmd,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic       ulpi_stp,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_oen
);

  if (TARGET == "") begin : g_no_target
  end

  typedef enum logic [2:0] {
    S_IDLE, S_TXCMD, S_WDATA, S_WSTP, S_RTURN, S_RDATA, S_RWAIT, S_ABWAIT
  } state_t;

  localparam logic [TOW-1:0] TIMER_ONE = {{(TOW-1){1'b0}}, 1'b1};

  state_t         state, state_nxt;
  logic           lat_write;
  logic [5:0]     lat_addr;
  logic [7:0]     lat_wdata;
  logic [TOW-1:0] timer;
  logic           dir_q;
  logic           timeout;
  logic           complete;
  logic           complete_err;
  logic           rdata_load;
  logic           rx_capture;

  assign req_ready  = (state == S_IDLE) && req_valid && !ulpi_dir;
  assign busy       = (state != S_IDLE);
  assign ulpi_oen   = ulpi_dir;
  assign timeout    = (state != S_IDLE) && (&timer);
  assign rx_capture = ulpi_dir && dir_q && !ulpi_nxt && (state != S_RDATA);

  always_comb begin
    state_nxt    = state;
    complete     = 1'b0;
    complete_err = 1'b0;
    rdata_load   = 1'b0;
    if (timeout) begin
      // timeout overrides whatever the bus is doing this cycle
      state_nxt    = S_IDLE;
      complete     = 1'b1;
      complete_err = 1'b1;
    end else begin
      case (state)
        S_IDLE:   if (req_ready) state_nxt = S_TXCMD;
        S_TXCMD: begin
          if (ulpi_dir)      state_nxt = S_ABWAIT;
          else if (ulpi_nxt) state_nxt = lat_write ? S_WDATA : S_RTURN;
        end
        S_ABWAIT: if (!ulpi_dir) state_nxt = S_TXCMD;
        S_WDATA: begin
          if (ulpi_dir) begin
            state_nxt    = S_IDLE;
            complete     = 1'b1;
            complete_err = 1'b1;
          end else if (ulpi_nxt) begin
            state_nxt = S_WSTP;
          end
        end
        S_WSTP: begin
          state_nxt = S_IDLE;
          complete  = 1'b1;
        end
        S_RTURN:  if (ulpi_dir) state_nxt = S_RDATA;
        S_RDATA: begin
          if (ulpi_dir) begin
            rdata_load = 1'b1;
            state_nxt  = S_RWAIT;
          end else begin
            state_nxt    = S_IDLE;
            complete     = 1'b1;
            complete_err = 1'b1;
          end
        end
        S_RWAIT: begin
          if (!ulpi_dir) begin
            state_nxt = S_IDLE;
            complete  = 1'b1;
          end
        end
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ulpi_data_out = 8'h00;
    ulpi_stp      = 1'b0;
    case (state)
      S_TXCMD: ulpi_data_out = {(lat_write ? 2'b10 : 2'b11), lat_addr};
      S_WDATA: ulpi_data_out = lat_wdata;
      S_WSTP:  ulpi_stp      = 1'b1;
      default: ulpi_data_out = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      lat_write   <= 1'b0;
      lat_addr    <= 6'h00;
      lat_wdata   <= 8'h00;
      timer       <= '0;
      dir_q       <= 1'b0;
      done_valid  <= 1'b0;
      done_err    <= 1'b0;
      done_rdata  <= 8'h00;
      rxcmd       <= 8'h00;
      rxcmd_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      dir_q       <= ulpi_dir;
      done_valid  <= complete;
      done_err    <= complete && complete_err;
      rxcmd_valid <= rx_capture;
      if (req_ready) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        timer     <= '0;
      end else if (state != S_IDLE) begin
        timer <= timer + TIMER_ONE;
      end
      if (rdata_load) done_rdata <= ulpi_data_in;
      if (rx_capture) rxcmd <= ulpi_data_in;
    end
  end

endmodule

// File: tb/tb_la_ulpi_regctl.sv
// Self-checking bench for la_ulpi_regctl: table of register transactions with a
// behavioural PHY, completion scoreboard, plus hand sequences for RX CMD and reset.
module tb_la_ulpi_regctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready, done_valid, done_err, busy, rxcmd_valid;
  logic [7:0] done_rdata, rxcmd;
  logic       ulpi_dir, ulpi_nxt, ulpi_stp, ulpi_oen;
  logic [7:0] ulpi_data_in, ulpi_data_out;

  la_ulpi_regctl #(.TOW(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .done_valid(done_valid), .done_err(done_err), .done_rdata(done_rdata),
    .busy(busy), .rxcmd_valid(rxcmd_valid), .rxcmd(rxcmd),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_in(ulpi_data_in),
    .ulpi_stp(ulpi_stp), .ulpi_data_out(ulpi_data_out), .ulpi_oen(ulpi_oen)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    logic [5:0] addr;
    logic [7:0] wdata;
    int         stall_cmd;
    int         stall_dat;
    int         ab_len;
    bit         dat_abort;
    bit         rd_short;
    bit         no_dir;
    logic [7:0] rd_byte;
    bit         err;
    int         lat;
  } vec_t;

  typedef struct {
    bit         err;
    bit         rd;
    logic [7:0] rdata;
    int         due;
  } exp_t;

  vec_t tbl[9];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rx_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rxcmd_valid) rx_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // completion scoreboard
  always @(negedge clk) begin
    if (!reset && done_valid) begin
      exp_t e;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL spurious_done: got done_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        if (done_err !== e.err || cyc != e.due || (e.rd && !e.err && done_rdata !== e.rdata)) begin
          n_err++;
          $display("FAIL done: got err=%0b cyc=%0d rdata=0x%0h expected err=%0b cyc=%0d rdata=0x%0h",
                   done_err, cyc, done_rdata, e.err, e.due, e.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input vec_t v);
    logic [7:0] cmd;
    cmd = {(v.wr ? 2'b10 : 2'b11), v.addr};
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_in = 8'h00;
    #1; chk("req_ready", req_ready, 1);
    sb.push_back('{v.err, !v.wr, v.rd_byte, cyc + v.lat});
    tick(); req_valid = 1'b0;
    if (v.ab_len > 0) begin
      ulpi_dir = 1'b1; ulpi_data_in = 8'h4D;
      for (int i = 0; i < v.ab_len; i++) begin
        #1; chk("abort_oen", ulpi_oen, 1);
        tick();
      end
      ulpi_dir = 1'b0; ulpi_data_in = 8'h00;
      #1; chk("abwait_bus", ulpi_data_out, 8'h00);
      tick();
    end
    for (int i = 0; i < v.stall_cmd; i++) begin
      #1; chk("txcmd_hold", ulpi_data_out, cmd);
      tick();
    end
    ulpi_nxt = 1'b1;
    #1; chk("txcmd", ulpi_data_out, cmd);
    tick();
    ulpi_nxt = 1'b0;
    if (v.wr) begin
      if (v.dat_abort) begin
        ulpi_dir = 1'b1;
        #1; chk("wdata_abort_bus", ulpi_data_out, v.wdata);
        tick();
        ulpi_dir = 1'b0;
      end else begin
        for (int i = 0; i < v.stall_dat; i++) begin
          #1; chk("wdata_hold", ulpi_data_out, v.wdata);
          tick();
        end
        ulpi_nxt = 1'b1;
        #1; chk("wdata", ulpi_data_out, v.wdata);
        tick();
        ulpi_nxt = 1'b0;
        #1; chk("wstp_stp", ulpi_stp, 1); chk("wstp_bus", ulpi_data_out, 8'h00);
        tick();
      end
    end else if (v.no_dir) begin
      for (int k = 0; k < 40; k++) begin
        #1;
        if (done_valid) break;
        chk("timeout_no_stp", ulpi_stp, 0);
        tick();
      end
      chk("timeout_done_seen", done_valid, 1);
    end else begin
      ulpi_dir = 1'b1; ulpi_data_in = 8'hEE;
      #1; chk("rturn_bus", ulpi_data_out, 8'h00);
      tick();
      ulpi_data_in = v.rd_byte;
      if (v.rd_short) ulpi_dir = 1'b0;
      #1; chk("rdata_busy", busy, 1);
      tick();
      if (!v.rd_short) begin
        ulpi_dir = 1'b0; ulpi_data_in = 8'h00;
        tick();
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0;
    //          wr  addr   wdata  sc sd ab dab rsh ndir rd     err lat
    tbl[0] = '{1, 6'h04, 8'h45, 0, 0, 0, 0,  0,  0,  8'h00, 0,  4};
    tbl[1] = '{0, 6'h0A, 8'h00, 0, 0, 0, 0,  0,  0,  8'h3C, 0,  5};
    tbl[2] = '{1, 6'h04, 8'h45, 3, 0, 0, 0,  0,  0,  8'h00, 0,  7};
    tbl[3] = '{1, 6'h2A, 8'hA5, 0, 2, 0, 0,  0,  0,  8'h00, 0,  6};
    tbl[4] = '{0, 6'h3F, 8'h00, 2, 0, 0, 0,  0,  0,  8'h81, 0,  7};
    tbl[5] = '{1, 6'h15, 8'h5A, 0, 0, 5, 0,  0,  0,  8'h00, 0, 10};
    tbl[6] = '{1, 6'h01, 8'h77, 0, 0, 0, 1,  0,  0,  8'h00, 1,  3};
    tbl[7] = '{0, 6'h22, 8'h00, 0, 0, 0, 0,  1,  0,  8'h66, 1,  4};
    tbl[8] = '{0, 6'h11, 8'h00, 0, 0, 0, 0,  0,  1,  8'h00, 1, 17};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 6'h00; req_wdata = 8'h00;
    ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_in = 8'h00;
    tick(); tick();
    chk("rst_bus", ulpi_data_out, 8'h00); chk("rst_stp", ulpi_stp, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done_valid, 0);
    chk("rst_rdata", done_rdata, 8'h00); chk("rst_rxcmd", rxcmd, 8'h00);
    reset = 1'b0;
    tick();

    // RX CMD in IDLE: packet bytes (nxt=1) ignored, request blocked while dir=1
    req_valid = 1'b1; req_write = 1'b1; ulpi_dir = 1'b1; ulpi_nxt = 1'b1; ulpi_data_in = 8'h99;
    #1; chk("ready_blocked_by_dir", req_ready, 0);
    tick();
    tick();
    ulpi_nxt = 1'b0; ulpi_data_in = 8'h2E; req_valid = 1'b0;
    #1; chk("rx_packet_ignored", rxcmd_valid, 0);
    tick();
    chk("rxcmd_pulse", rxcmd_valid, 1); chk("rxcmd_byte", rxcmd, 8'h2E);
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00;
    tick();
    chk("rxcmd_pulse_end", rxcmd_valid, 0); chk("idle_busy", busy, 0);

    for (int i = 0; i < 9; i++) begin
      rx0 = rx_cnt;
      do_txn(tbl[i]);
      if (tbl[i].ab_len > 0) begin
        chk("abort_rxcmd", rxcmd, 8'h4D);
        chk("abort_rxcmd_seen", (rx_cnt > rx0), 1);
      end
    end
    tick(); tick();
    chk("rdata_held", done_rdata, 8'h81);

    // reset while in WDATA drops the transaction silently
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h07; req_wdata = 8'h33;
    tick(); req_valid = 1'b0; ulpi_nxt = 1'b1;
    tick(); ulpi_nxt = 1'b0;
    #1; chk("pre_reset_wdata", ulpi_data_out, 8'h33);
    reset = 1'b1;
    #1;
    chk("mid_rst_bus", ulpi_data_out, 8'h00); chk("mid_rst_stp", ulpi_stp, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_rdata", done_rdata, 8'h00);
    chk("mid_rst_rxcmd", rxcmd, 8'h00); chk("mid_rst_done", done_valid, 0);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    do_txn(tbl[0]);
    tick(); tick();
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
